pmem_responder: RTL and testbench

- Line-granular physical-memory responder; it sits at the far end of the pmem_* interface driven by the L2 cache.
- Accepts one 128-bit line read or write at a time, waits a programmable number of cycles, then performs the access on internal line storage.
- Returns a single-cycle pmem_resp pulse.
- Serves as the synthesizable main-memory model for L2 bring-up and for system simulation.

---
 rtl/pmem_responder.sv | 104 ++++++++++
 tb/tb_pmem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular main-memory model: one 128-bit read or write at a time,
// a fixed wait of LATENCY cycles, then a single-cycle pmem_resp pulse.
module pmem_responder #(
  parameter int LATENCY = 8,
  parameter int LINES   = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata
);
  localparam int IW = $clog2(LINES);

  typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   init_idx, idx;
  logic [7:0]      cnt;
  logic            op_wr;
  logic [127:0]    wdata_q;
  logic [127:0]    mem [LINES];

  logic            req, last_init, fire;
  logic            mem_we;
  logic [IW-1:0]   mem_addr;
  logic [127:0]    mem_din;
  logic            unused_addr;

  assign req       = pmem_read | pmem_write;
  assign last_init = (init_idx == IW'(LINES - 1));
  assign fire      = (state == BUSY) && (cnt == 8'd0);

  // Line offset and aliased upper bits are deliberately dropped.
  assign unused_addr = ^{pmem_address[3:0], pmem_address >> (4 + IW)};

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (last_init) state_n = IDLE;
      IDLE:    if (req)       state_n = BUSY;
      BUSY:    if (cnt == 8'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_comb begin
    pmem_resp = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_idx   <= '0;
      cnt        <= '0;
      idx        <= '0;
      op_wr      <= 1'b0;
      wdata_q    <= '0;
      pmem_rdata <= '0;
    end else begin
      case (state)
        INIT: init_idx <= init_idx + IW'(1);
        IDLE: if (req) begin
          idx     <= pmem_address[4 +: IW];
          op_wr   <= pmem_write;
          wdata_q <= pmem_wdata;
          cnt     <= 8'(LATENCY - 1);
        end
        BUSY: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             pmem_rdata <= op_wr ? wdata_q : mem[idx];
        end
        default: ;
      endcase
    end
  end

  // Single write port shared by the clearing sweep and request writes;
  // the two never overlap because they live in different states.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = idx;
    mem_din  = wdata_q;
    if (state == INIT) begin
      mem_we   = 1'b1;
      mem_addr = init_idx;
      mem_din  = '0;
    end else if (fire && op_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_addr] <= mem_din;
  end
endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a cycle-level timing model plus a
// flat line array predicts each pmem_resp cycle and its pmem_rdata.
module tb_pmem_responder;
  localparam int LATENCY = 8;
  localparam int LINES   = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  pmem_responder #(.LATENCY(LATENCY), .LINES(LINES)) dut (
    .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           c;
    logic [127:0] d;
  } exp_t;

  exp_t         q[$];
  exp_t         e_m;
  int           tests = 0, fails = 0;
  int           cyc = 0;
  int           ready = 0;
  logic [127:0] model_mem [LINES];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (pmem_resp) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp cycle=%0d rdata=%h", cyc, pmem_rdata);
      end else begin
        e_m = q.pop_front();
        if (cyc != e_m.c) begin
          fails++;
          $display("FAIL resp_cycle got=%0d exp=%0d", cyc, e_m.c);
        end
        tests++;
        if (pmem_rdata !== e_m.d) begin
          fails++;
          $display("FAIL rdata cycle=%0d got=%h exp=%h", cyc, pmem_rdata, e_m.d);
        end
      end
    end
  end

  task automatic clr_model();
    foreach (model_mem[i]) model_mem[i] = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge. A held request is taken in the first
  // free IDLE cycle and answered LATENCY+1 cycles later.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [127:0] d, input bit scramble);
    int   t, rc, li, n;
    exp_t e;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = d;
    t  = (cyc > ready) ? cyc : ready;
    rc = t + LATENCY + 1;
    li = int'(a >> 4) % LINES;
    if (wr) begin
      model_mem[li] = d;
      e.d = d;
    end else begin
      e.d = model_mem[li];
    end
    e.c = rc;
    q.push_back(e);
    ready = rc + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!pmem_resp && scramble && cyc > t) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        pmem_read    = 1'($urandom_range(0, 1));
        pmem_write   = 1'($urandom_range(0, 1));
      end
    end while (!pmem_resp && n < 2000);
    if (!pmem_resp) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout addr=%h got=no_resp exp=resp_at_%0d", a, rc);
    end
    next_cycle();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    int          t;
    logic [15:0] a;
    int          op;
    reset = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    clr_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0) begin
      fails++;
      $display("FAIL reset_state got=%b/%h exp=0/0", pmem_resp, pmem_rdata);
    end
    next_cycle();

    // Read held across reset release: answered after the clearing sweep.
    reset = 1'b0;
    ready = cyc + LINES;
    do_req(1, 0, 16'h0040, '0, 0);

    do_req(0, 1, 16'h0120, 128'hDEADBEEF_00112233_44556677_8899AABB, 0);
    do_req(1, 0, 16'h0120, '0, 0);
    do_req(1, 0, 16'h012E, '0, 0);

    do_req(0, 1, 16'h1010, 128'h1, 0);
    do_req(1, 0, 16'h0010, '0, 0);

    // Back-to-back: each request issued the cycle after the previous pulse.
    do_req(1, 0, 16'h0120, '0, 0);
    do_req(1, 0, 16'h0010, '0, 0);
    do_req(1, 0, 16'h0040, '0, 0);

    // Reset while the write is in flight with three wait cycles left.
    pmem_write   = 1'b1;
    pmem_address = 16'h0200;
    pmem_wdata   = 128'hFF;
    t = (cyc > ready) ? cyc : ready;
    while (cyc < t + 5) next_cycle();
    reset = 1'b1;
    pmem_write = 1'b0;
    next_cycle();
    reset = 1'b0;
    ready = cyc + LINES;
    clr_model();
    @(negedge clk);
    tests++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0) begin
      fails++;
      $display("FAIL midbusy_reset got=%b/%h exp=0/0", pmem_resp, pmem_rdata);
    end
    next_cycle();
    do_req(1, 0, 16'h0200, '0, 0);
    do_req(1, 0, 16'h0120, '0, 0);

    do_req(1, 1, 16'h0300, 128'hA5, 0);
    do_req(1, 0, 16'h0300, '0, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) next_cycle();
      a  = 16'($urandom) & 16'hF07F;
      op = int'($urandom_range(0, 2));
      do_req(op != 1, op != 0, a, {$urandom, $urandom, $urandom, $urandom}, 1);
    end

    repeat (LATENCY + 4) next_cycle();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL outstanding got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
